// File: rtl/mem_requester.sv
// rtl/mem_requester.sv - single-port memory requester: fetch/load/store sequencing with range check and counters
module mem_requester #(
    parameter int CODE_DEPTH = 19,
    parameter int DATA_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_req,
    input  logic        load_req,
    input  logic        store_req,
    input  logic [31:0] pc,
    input  logic [31:0] daddr,
    input  logic [31:0] wdata,
    input  logic [31:0] IR,
    input  logic [31:0] DR,
    output logic [31:0] addr,
    output logic        WR,
    output logic        IR_DR,
    output logic [31:0] MDataIn,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] instr,
    output logic [31:0] rdata,
    output logic [15:0] fetch_cnt,
    output logic [15:0] load_cnt,
    output logic [15:0] store_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_CAPTURE} state_t;
    typedef enum logic [1:0] {OP_FETCH, OP_LOAD, OP_STORE} op_t;

    state_t      state_q;
    op_t         op_q;
    logic [31:0] addr_q;
    logic        wr_q;
    logic        ir_dr_q;
    logic [31:0] mdata_q;
    logic        done_q;
    logic        err_q;
    logic [31:0] instr_q;
    logic [31:0] rdata_q;
    logic [15:0] fetch_cnt_q, load_cnt_q, store_cnt_q;
    logic [15:0] fetch_cnt_d, load_cnt_d, store_cnt_d;
    logic        code_oor;
    logic        data_oor;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Range checks and saturating counter next values
    always_comb begin
        code_oor    = (pc >= 32'(CODE_DEPTH));
        data_oor    = (daddr >= 32'(DATA_DEPTH));
        fetch_cnt_d = sat_inc(fetch_cnt_q);
        load_cnt_d  = sat_inc(load_cnt_q);
        store_cnt_d = sat_inc(store_cnt_q);
    end

    // Access sequencer; reset is asynchronous so WR returns high at once and no partial write occurs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            op_q        <= OP_FETCH;
            addr_q      <= 32'd0;
            wr_q        <= 1'b1;
            ir_dr_q     <= 1'b0;
            mdata_q     <= 32'd0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            instr_q     <= 32'd0;
            rdata_q     <= 32'd0;
            fetch_cnt_q <= 16'd0;
            load_cnt_q  <= 16'd0;
            store_cnt_q <= 16'd0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    // store wins over load, load over fetch; losers are dropped
                    if (store_req) begin
                        if (data_oor) begin
                            state_q <= S_CAPTURE;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                        end else begin
                            op_q    <= OP_STORE;
                            addr_q  <= daddr;
                            wr_q    <= 1'b0;
                            ir_dr_q <= 1'b1;
                            mdata_q <= wdata;
                            state_q <= S_ISSUE;
                        end
                    end else if (load_req) begin
                        if (data_oor) begin
                            state_q <= S_CAPTURE;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                        end else begin
                            op_q    <= OP_LOAD;
                            addr_q  <= daddr;
                            ir_dr_q <= 1'b1;
                            state_q <= S_ISSUE;
                        end
                    end else if (fetch_req) begin
                        if (code_oor) begin
                            state_q <= S_CAPTURE;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                        end else begin
                            op_q    <= OP_FETCH;
                            addr_q  <= pc;
                            ir_dr_q <= 1'b0;
                            state_q <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    if (op_q == OP_STORE) begin
                        wr_q        <= 1'b1;
                        store_cnt_q <= store_cnt_d;
                        done_q      <= 1'b1;
                        state_q     <= S_IDLE;
                    end else begin
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // memory output registered at the previous edge is valid now
                    if (op_q == OP_FETCH) begin
                        instr_q     <= IR;
                        fetch_cnt_q <= fetch_cnt_d;
                    end else begin
                        rdata_q    <= DR;
                        load_cnt_q <= load_cnt_d;
                    end
                    done_q  <= 1'b1;
                    state_q <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign addr      = addr_q;
    assign WR        = wr_q;
    assign IR_DR     = ir_dr_q;
    assign MDataIn   = mdata_q;
    assign done      = done_q;
    assign err       = err_q;
    assign instr     = instr_q;
    assign rdata     = rdata_q;
    assign fetch_cnt = fetch_cnt_q;
    assign load_cnt  = load_cnt_q;
    assign store_cnt = store_cnt_q;

endmodule

// File: tb/tb_mem_requester.sv
// tb/tb_mem_requester.sv - scoreboard bench for mem_requester
module tb_mem_requester;

    logic        clk;
    logic        reset;
    logic        fetch_req, load_req, store_req;
    logic [31:0] pc, daddr, wdata, IR, DR;
    logic [31:0] addr, MDataIn, instr, rdata;
    logic        WR, IR_DR, busy, done, err;
    logic [15:0] fetch_cnt, load_cnt, store_cnt;

    mem_requester #(.CODE_DEPTH(19), .DATA_DEPTH(8)) dut (
        .clk(clk), .reset(reset),
        .fetch_req(fetch_req), .load_req(load_req), .store_req(store_req),
        .pc(pc), .daddr(daddr), .wdata(wdata), .IR(IR), .DR(DR),
        .addr(addr), .WR(WR), .IR_DR(IR_DR), .MDataIn(MDataIn),
        .busy(busy), .done(done), .err(err),
        .instr(instr), .rdata(rdata),
        .fetch_cnt(fetch_cnt), .load_cnt(load_cnt), .store_cnt(store_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: synchronous write on WR=0, registered read data
    logic [31:0] cmem [0:31];
    logic [31:0] dmem [0:7];
    always @(posedge clk) begin
        if (!WR) dmem[addr[2:0]] <= MDataIn;
        IR <= cmem[addr[4:0]];
        DR <= dmem[addr[2:0]];
    end

    int checks   = 0;
    int failures = 0;
    int wr_low   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        err;
        logic [1:0]  kind;   // 0 fetch, 1 load, 2 store
        logic [31:0] val;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb[$];
    exp_t m_e;

    // Write strobe tracker
    always @(negedge clk) if (reset && !WR) wr_low++;

    // Monitor: pops one expectation per done pulse
    always @(negedge clk) begin
        if (reset && done) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=1 expected=0");
            end else begin
                m_e = sb.pop_front();
                chk("done_err", 32'(err), 32'(m_e.err));
                case (m_e.kind)
                    2'd0: begin
                        chk("instr", instr, m_e.val);
                        chk("fetch_cnt", 32'(fetch_cnt), 32'(m_e.cnt));
                    end
                    2'd1: begin
                        chk("rdata", rdata, m_e.val);
                        chk("load_cnt", 32'(load_cnt), 32'(m_e.cnt));
                    end
                    default: begin
                        chk("mdatain", MDataIn, m_e.val);
                        chk("store_cnt", 32'(store_cnt), 32'(m_e.cnt));
                    end
                endcase
            end
        end
    end

    // reqs = {store, load, fetch}; called at a negedge, returns at a negedge
    task automatic do_req(input logic [2:0] reqs, input logic [1:0] kind,
                          input logic [31:0] a_pc, input logic [31:0] a_d, input logic [31:0] wd,
                          input logic e_err, input logic [31:0] e_val, input logic [15:0] e_cnt,
                          input int e_lat);
        exp_t e;
        int lat;
        int wr0;
        e.err = e_err; e.kind = kind; e.val = e_val; e.cnt = e_cnt;
        sb.push_back(e);
        wr0 = wr_low;
        pc = a_pc; daddr = a_d; wdata = wd;
        {store_req, load_req, fetch_req} = reqs;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!done && lat < 10);
        {store_req, load_req, fetch_req} = 3'b000;
        chk("latency", 32'(lat), 32'(e_lat));
        chk("wr_pulses", 32'(wr_low - wr0), (kind == 2'd2 && !e_err) ? 32'd1 : 32'd0);
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) cmem[i] = 32'h1000_0000 + 32'(i);
        cmem[1] = 32'h8C20_0003;
        reset = 1'b0;
        fetch_req = 0; load_req = 0; store_req = 0;
        pc = 0; daddr = 0; wdata = 0;
        repeat (2) @(negedge clk);
        chk("rst_addr", addr, 32'd0);
        chk("rst_wr", 32'(WR), 32'd1);
        chk("rst_ir_dr", 32'(IR_DR), 32'd0);
        chk("rst_mdata", MDataIn, 32'd0);
        chk("rst_busy_done_err", {29'd0, busy, done, err}, 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_cnts", {fetch_cnt, load_cnt}, 32'd0);
        chk("rst_store_cnt", 32'(store_cnt), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // fetch pc=1
        do_req(3'b001, 2'd0, 32'd1, 0, 0, 1'b0, 32'h8C20_0003, 16'd1, 3);
        // store daddr=0 wdata=AC
        do_req(3'b100, 2'd2, 0, 32'd0, 32'h0000_00AC, 1'b0, 32'h0000_00AC, 16'd1, 2);
        chk("store_addr", addr, 32'd0);
        chk("store_ir_dr", 32'(IR_DR), 32'd1);
        // load back
        do_req(3'b010, 2'd1, 0, 32'd0, 0, 1'b0, 32'h0000_00AC, 16'd1, 3);
        chk("load_ir_dr", 32'(IR_DR), 32'd1);
        do_req(3'b100, 2'd2, 0, 32'd5, 32'h1234_5678, 1'b0, 32'h1234_5678, 16'd2, 2);
        chk("store5_addr", addr, 32'd5);
        do_req(3'b010, 2'd1, 0, 32'd5, 0, 1'b0, 32'h1234_5678, 16'd2, 3);
        // collision: store wins
        do_req(3'b111, 2'd2, 32'd2, 32'd3, 32'h0000_BEEF, 1'b0, 32'h0000_BEEF, 16'd3, 2);
        chk("collide_load_cnt", 32'(load_cnt), 32'd2);
        chk("collide_fetch_cnt", 32'(fetch_cnt), 32'd1);
        chk("collide_addr", addr, 32'd3);
        // out of range load and fetch
        do_req(3'b010, 2'd1, 0, 32'd8, 0, 1'b1, 32'h1234_5678, 16'd2, 1);
        do_req(3'b001, 2'd0, 32'd19, 0, 0, 1'b1, 32'h8C20_0003, 16'd1, 1);
        chk("oor_addr_held", addr, 32'd3);
        // top valid code address
        do_req(3'b001, 2'd0, 32'd18, 0, 0, 1'b0, 32'h1000_0012, 16'd2, 3);
        chk("fetch18_ir_dr", 32'(IR_DR), 32'd0);

        // reset during WAIT of a load
        daddr = 32'd0; load_req = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("wait_busy", 32'(busy), 32'd1);
        reset = 1'b0;
        #1;
        chk("abort_rdata", rdata, 32'd0);
        chk("abort_wr", 32'(WR), 32'd1);
        chk("abort_busy_done", {30'd0, busy, done}, 32'd0);
        chk("abort_cnts", {fetch_cnt, load_cnt}, 32'd0);
        chk("abort_store_cnt", 32'(store_cnt), 32'd0);
        load_req = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // saturation
        force dut.fetch_cnt_q = 16'hFFFE;
        #1;
        release dut.fetch_cnt_q;
        @(negedge clk);
        chk("preload", 32'(fetch_cnt), 32'h0000_FFFE);
        do_req(3'b001, 2'd0, 32'd0, 0, 0, 1'b0, 32'h1000_0000, 16'hFFFF, 3);
        do_req(3'b001, 2'd0, 32'd1, 0, 0, 1'b0, 32'h8C20_0003, 16'hFFFF, 3);
        do_req(3'b001, 2'd0, 32'd2, 0, 0, 1'b0, 32'h1000_0002, 16'hFFFF, 3);

        repeat (3) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_requester.md
MEM_REQUESTER -- requirements
Module: mem_requester

Interface
REQ-001 Parameter CODE_DEPTH, default 19, number of valid instruction words (addresses 0..CODE_DEPTH-1).
REQ-002 Parameter DATA_DEPTH, default 8, number of valid data words (addresses 0..DATA_DEPTH-1).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; asserted when 0.
REQ-005 fetch_req  input  1  request an instruction read at pc.
REQ-006 load_req  input  1  request a data read at daddr.
REQ-007 store_req  input  1  request a data write of wdata at daddr.
REQ-008 pc  input  32  instruction address.
REQ-009 daddr  input  32  data address.
REQ-010 wdata  input  32  store data.
REQ-011 IR  input  32  instruction word returned by the memory.
REQ-012 DR  input  32  data word returned by the memory.
REQ-013 addr  output  32  memory address, registered.
REQ-014 WR  output  1  memory write strobe; 0 = write, 1 = read; registered.
REQ-015 IR_DR  output  1  memory read select; 0 = code, 1 = data; registered.
REQ-016 MDataIn  output  32  memory write data, registered.
REQ-017 busy  output  1  high while the state is not IDLE.
REQ-018 done  output  1  one-cycle completion pulse.
REQ-019 err  output  1  one-cycle pulse, concurrent with done, flagging a rejected out-of-range request.
REQ-020 instr  output  32  last fetched instruction.
REQ-021 rdata  output  32  last loaded data word.
REQ-022 fetch_cnt, load_cnt, store_cnt  output  16 each  completed-access counters.

Function
REQ-023 FSM states: IDLE, ISSUE, WAIT, CAPTURE.
REQ-024 Requests are sampled only in IDLE; requests raised in any other state are ignored, and the requester holds its request until done.
REQ-025 When requests collide in IDLE, priority is store > load > fetch; the losing requests are ignored.
REQ-026 Memory writes on every edge at which WR=0, so WR idles at 1 in every state except ISSUE-of-store.
REQ-027 Outside ISSUE, IR_DR and addr hold their last values.
REQ-028 Accept edge k, in-range request: addr, WR and IR_DR (plus MDataIn for a store) are driven after edge k, and the state becomes ISSUE.
- fetch: WR=1, IR_DR=0, addr=pc.
- load: WR=1, IR_DR=1, addr=daddr.
- store: WR=0, addr=daddr, MDataIn=wdata.
REQ-029 Store: at edge k+1, WR returns to 1, store_cnt increments, state goes to IDLE, and done is high for the cycle after k+1.
REQ-030 Fetch/load: at edge k+1 the state goes ISSUE->WAIT, and the memory registers its output.
REQ-031 Fetch/load: at edge k+2 the state goes WAIT->CAPTURE, instr<=IR (fetch) or rdata<=DR (load), and the matching counter increments.
REQ-032 Fetch/load: done is high during CAPTURE, the cycle after k+2; at edge k+3 the state goes to IDLE, and a new request can be accepted at edge k+3.
REQ-033 Out-of-range check: pc >= CODE_DEPTH for a fetch, or daddr >= DATA_DEPTH for a load/store.
REQ-034 An out-of-range request drives no memory port change (WR stays 1), goes IDLE->CAPTURE, and pulses done and err together in the cycle after k.
REQ-035 For an out-of-range request, instr, rdata and the counters are unchanged.
REQ-036 Counters saturate at 16'hFFFF and do not wrap.
REQ-037 busy = (state != IDLE), combinational from the state.

Reset
REQ-038 reset=0 immediately forces: state IDLE, addr=0, WR=1, IR_DR=0, MDataIn=0, done=0, err=0, instr=0, rdata=0, all counters=0.
REQ-039 Reset mid-operation aborts the access without a completion pulse, and WR=1 takes effect asynchronously so that no partial write occurs.
REQ-040 After reset deasserts, the first rising edge may accept a request.

Verification
REQ-041 Fetch pc=1, memory IR=32'h8C200003 at k+2 -> instr=32'h8C200003, done in the cycle after k+2, fetch_cnt=1, WR=1 throughout.
REQ-042 Store daddr=0, wdata=32'hAC -> WR=0 for exactly one cycle with addr=0 and MDataIn=32'hAC, done the next cycle, store_cnt=1.
REQ-043 fetch_req, load_req and store_req high together at one edge -> only the store executes, load_cnt=0, fetch_cnt=0.
REQ-044 Load daddr=8 (DATA_DEPTH=8) -> done and err pulse one cycle after accept, WR stays 1, rdata unchanged, load_cnt unchanged.
REQ-045 reset=0 asserted during WAIT of a load -> outputs at reset values at once, no done pulse, rdata=0.
REQ-046 Preload fetch_cnt to 16'hFFFE, then do 3 in-range fetches -> fetch_cnt=16'hFFFF.
